// File: rtl/alu_mw_sequencer.sv
// rtl/alu_mw_sequencer.sv - multi-word ADD/SUB/INC/DEC sequencer driving a shared word-wide ALU
module alu_mw_sequencer #(
   parameter int DWIDTH = 8,
   parameter int NWORDS = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     CMD_VALID,
   output logic                     CMD_READY,
   input  logic [1:0]               CMD_OP,
   input  logic                     CMD_CB,
   input  logic [NWORDS*DWIDTH-1:0] CMD_A,
   input  logic [NWORDS*DWIDTH-1:0] CMD_B,
   output logic [3:0]               ALU_INSTR,
   output logic [DWIDTH-1:0]        ALU_A,
   output logic [DWIDTH-1:0]        ALU_B,
   output logic                     ALU_CIN,
   output logic                     ALU_BIN,
   input  logic [DWIDTH-1:0]        ALU_OUT,
   input  logic                     ALU_COUT,
   input  logic                     ALU_BOUT,
   output logic                     RES_VALID,
   input  logic                     RES_READY,
   output logic [NWORDS*DWIDTH-1:0] RES_DATA,
   output logic                     RES_CB,
   output logic                     RES_ZERO,
   output logic                     BUSY
);
   localparam int OW = NWORDS * DWIDTH;
   localparam int IW = $clog2(NWORDS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_idx;
   logic [1:0]      r_op;
   logic [OW-1:0]   r_a;
   logic [OW-1:0]   r_b;
   logic [OW-1:0]   r_res;
   logic            r_chain;
   logic            w_accept;
   logic            w_last;
   logic            w_sub;
   logic            w_unary;

   // op[0] selects subtract flavour, op[1] selects the B-less INC/DEC forms
   assign w_sub   = r_op[0];
   assign w_unary = r_op[1];
   assign w_last  = (r_idx == IW'(NWORDS - 1));

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      CMD_READY = 1'b0;
      BUSY      = 1'b0;
      RES_VALID = 1'b0;
      ALU_INSTR = 4'h0;
      ALU_A     = '0;
      ALU_B     = '0;
      ALU_CIN   = 1'b0;
      ALU_BIN   = 1'b0;
      case (r_state)
         S_IDLE: begin
            CMD_READY = 1'b1;
            if (CMD_VALID) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end
         end
         S_RUN: begin
            BUSY      = 1'b1;
            ALU_INSTR = w_sub ? 4'h4 : 4'h5;
            ALU_A     = r_a[DWIDTH-1:0];
            ALU_B     = w_unary ? '0 : r_b[DWIDTH-1:0];
            ALU_CIN   = ~w_sub & r_chain;
            ALU_BIN   = w_sub & r_chain;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            RES_VALID = 1'b1;
            if (RES_READY) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operands shift down a word per cycle; results shift in from the top so
   // the LSB word lands in place after NWORDS steps.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_idx   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_chain <= 1'b0;
      end else if (w_accept) begin
         r_idx   <= '0;
         r_op    <= CMD_OP;
         r_a     <= CMD_A;
         r_b     <= CMD_B;
         r_chain <= CMD_OP[1] | CMD_CB;
      end else if (r_state == S_RUN) begin
         r_a     <= r_a >> DWIDTH;
         r_b     <= r_b >> DWIDTH;
         r_res   <= {ALU_OUT, r_res[OW-1:DWIDTH]};
         r_chain <= w_sub ? ALU_BOUT : ALU_COUT;
         r_idx   <= w_last ? '0 : r_idx + 1'b1;
      end
   end

   assign RES_DATA = r_res;
   assign RES_CB   = (r_state == S_DONE) & r_chain;
   assign RES_ZERO = (r_state == S_DONE) && (r_res == '0);
endmodule

// File: tb/tb_alu_mw_sequencer.sv
// tb/tb_alu_mw_sequencer.sv - randomized self-checking bench with an arithmetic reference model
module tb_alu_mw_sequencer;
   localparam int DWIDTH = 8;
   localparam int NWORDS = 4;
   localparam int OW     = NWORDS * DWIDTH;

   logic              CLK, RST;
   logic              CMD_VALID, CMD_READY, CMD_CB;
   logic [1:0]        CMD_OP;
   logic [OW-1:0]     CMD_A, CMD_B;
   logic [3:0]        ALU_INSTR;
   logic [DWIDTH-1:0] ALU_A, ALU_B, ALU_OUT;
   logic              ALU_CIN, ALU_BIN, ALU_COUT, ALU_BOUT;
   logic              RES_VALID, RES_READY, RES_CB, RES_ZERO, BUSY;
   logic [OW-1:0]     RES_DATA;

   int n_checks = 0;
   int n_errors = 0;

   alu_mw_sequencer #(.DWIDTH(DWIDTH), .NWORDS(NWORDS)) dut (
      .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_OP(CMD_OP), .CMD_CB(CMD_CB), .CMD_A(CMD_A), .CMD_B(CMD_B),
      .ALU_INSTR(ALU_INSTR), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN),
      .ALU_BIN(ALU_BIN), .ALU_OUT(ALU_OUT), .ALU_COUT(ALU_COUT), .ALU_BOUT(ALU_BOUT),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
      .RES_CB(RES_CB), .RES_ZERO(RES_ZERO), .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Word-wide ALU that the sequencer drives
   always_comb begin
      ALU_OUT  = '0;
      ALU_COUT = 1'b0;
      ALU_BOUT = 1'b0;
      if (ALU_INSTR == 4'h5)
         {ALU_COUT, ALU_OUT} = {1'b0, ALU_A} + {1'b0, ALU_B} + (DWIDTH+1)'(ALU_CIN);
      else if (ALU_INSTR == 4'h4)
         {ALU_BOUT, ALU_OUT} = {1'b0, ALU_A} - {1'b0, ALU_B} - (DWIDTH+1)'(ALU_BIN);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Carry/borrow entering word i, from whole-number arithmetic on the low i words
   function automatic logic chain_in(input logic [1:0] op, input logic cb,
                                     input logic [OW-1:0] a, input logic [OW-1:0] b, input int i);
      logic [OW:0] m, av, bv, c0, s;
      c0 = op[1] ? (OW+1)'(1) : (OW+1)'(cb);
      m  = (OW+1)'(1) << (DWIDTH * i);
      m  = m - 1'b1;
      av = {1'b0, a} & m;
      bv = op[1] ? '0 : ({1'b0, b} & m);
      if (!op[0]) begin
         s = av + bv + c0;
         return s[DWIDTH * i];
      end
      return av < (bv + c0);
   endfunction

   function automatic logic [OW-1:0] model_res(input logic [1:0] op, input logic cb,
                                                input logic [OW-1:0] a, input logic [OW-1:0] b);
      logic [OW-1:0] bv, c0;
      bv = op[1] ? '0 : b;
      c0 = op[1] ? OW'(1) : OW'(cb);
      return op[0] ? a - bv - c0 : a + bv + c0;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_cmd_ready"}, CMD_READY, 1);
      chk({tag, "_busy"},      BUSY, 0);
      chk({tag, "_res_valid"}, RES_VALID, 0);
      chk({tag, "_res_zero"},  RES_ZERO, 0);
      chk({tag, "_res_cb"},    RES_CB, 0);
      chk({tag, "_alu_instr"}, ALU_INSTR, 0);
      chk({tag, "_alu_ab"},    {ALU_A, ALU_B, ALU_CIN, ALU_BIN}, 0);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic cb, input logic [OW-1:0] a,
                          input logic [OW-1:0] b, input int stall, input bit noise);
      logic [OW-1:0] exp_res, sh;
      logic          exp_cb;
      exp_res = model_res(op, cb, a, b);
      exp_cb  = chain_in(op, cb, a, b, NWORDS);
      @(negedge CLK);
      chk("accept_ready", CMD_READY, 1);
      CMD_VALID = 1'b1; CMD_OP = op; CMD_CB = cb; CMD_A = a; CMD_B = b;
      @(posedge CLK);
      #1;
      CMD_VALID = noise; CMD_OP = 2'($urandom); CMD_CB = 1'($urandom);
      CMD_A = OW'($urandom); CMD_B = OW'($urandom);
      for (int i = 0; i < NWORDS; i++) begin
         @(negedge CLK);
         sh = a >> (DWIDTH * i);
         chk("run_busy", {BUSY, CMD_READY, RES_VALID}, 3'b100);
         chk("run_instr", ALU_INSTR, op[0] ? 4'h4 : 4'h5);
         chk("run_alu_a", ALU_A, sh[DWIDTH-1:0]);
         sh = op[1] ? '0 : (b >> (DWIDTH * i));
         chk("run_alu_b", ALU_B, sh[DWIDTH-1:0]);
         chk("run_cin", ALU_CIN, op[0] ? 1'b0 : chain_in(op, cb, a, b, i));
         chk("run_bin", ALU_BIN, op[0] ? chain_in(op, cb, a, b, i) : 1'b0);
         RES_READY = 1'($urandom);
         CMD_VALID = noise & 1'($urandom);
         CMD_A = OW'($urandom);
      end
      for (int s = 0; s <= stall; s++) begin
         @(negedge CLK);
         chk("done_valid", {RES_VALID, CMD_READY, BUSY}, 3'b100);
         chk("done_data", RES_DATA, exp_res);
         chk("done_cb", RES_CB, exp_cb);
         chk("done_zero", RES_ZERO, exp_res == '0);
         chk("done_alu_nop", ALU_INSTR, 0);
         RES_READY = (s == stall);
         CMD_VALID = (s == stall) ? 1'b0 : noise & 1'($urandom);
      end
      @(negedge CLK);
      chk_idle("post_done");
      RES_READY = 1'b0;
   endtask

   task automatic reset_mid_run(input logic [OW-1:0] a, input logic [OW-1:0] b);
      @(negedge CLK);
      CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_CB = 1'b0; CMD_A = a; CMD_B = b;
      @(negedge CLK);
      CMD_VALID = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_at_idx2", ALU_A, a[2*DWIDTH +: DWIDTH]);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk_idle("after_rst");
      chk("after_rst_data", RES_DATA, 0);
      RES_READY = 1'b1;
      @(negedge CLK);
      chk_idle("after_rst_hold");
      RES_READY = 1'b0;
   endtask

   initial begin
      logic [1:0]    op;
      logic [OW-1:0] a, b;
      RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_CB = 1'b0;
      CMD_A = '0; CMD_B = '0; RES_READY = 1'b0;
      repeat (2) @(negedge CLK);
      chk_idle("reset");
      chk("reset_data", RES_DATA, 0);
      RST = 1'b0;

      run_cmd(2'b00, 1'b0, 32'h000000FF, 32'h00000001, 0, 0);
      run_cmd(2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000001, 0, 0);
      run_cmd(2'b00, 1'b1, 32'h00000004, 32'h00000002, 0, 0);
      run_cmd(2'b01, 1'b0, 32'h00000100, 32'h00000001, 0, 0);
      run_cmd(2'b01, 1'b1, 32'h00000003, 32'h0000001F, 0, 0);
      run_cmd(2'b10, 1'b0, 32'h00FFFFFF, 32'hDEADBEEF, 0, 0);
      run_cmd(2'b11, 1'b1, 32'h00000000, 32'h12345678, 0, 0);
      run_cmd(2'b11, 1'b0, 32'h00000070, 32'h0, 0, 0);
      run_cmd(2'b00, 1'b1, 32'h89ABCDEF, 32'h76543210, 5, 1);
      reset_mid_run(32'hCAFEF00D, 32'h01020304);
      run_cmd(2'b00, 1'b0, 32'h12345678, 32'h11111111, 0, 0);

      for (int n = 0; n < 40; n++) begin
         op = 2'($urandom);
         a  = OW'($urandom);
         b  = OW'($urandom);
         case ($urandom_range(0, 3))
            0: a = '0;
            1: a = '1;
            2: b = '1;
            default: ;
         endcase
         run_cmd(op, 1'($urandom), a, b, $urandom_range(0, 2), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/alu_mw_sequencer.md
Name: alu_mw_sequencer

Overview:
- Multi-word arithmetic sequencer that time-shares one DWIDTH-bit `alu` instance.
- Executes NWORDS*DWIDTH-bit ADD/SUB/INC/DEC one word per cycle, LSB word first.
- Chains ALU Cout/Bout back into Cin/Bin between words.
- Sits between the CPU control path (command/result valid-ready handshakes) and the `alu` ports; the `alu` is instantiated outside this block.

Parameters:
- DWIDTH, 8, ALU data width (bits per word).
- NWORDS, 4, words per operand (min 2); operand width = NWORDS*DWIDTH.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RST  input  1  synchronous active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  block can accept a command.
- CMD_OP  input  2  00 ADD, 01 SUB, 10 INC, 11 DEC.
- CMD_CB  input  1  initial carry-in (ADD) / borrow-in (SUB); ignored for INC/DEC.
- CMD_A  input  NWORDS*DWIDTH  operand A.
- CMD_B  input  NWORDS*DWIDTH  operand B (ignored for INC/DEC).
- ALU_INSTR  output  4  to alu IN_INSTR.
- ALU_A  output  DWIDTH  to alu IN_A.
- ALU_B  output  DWIDTH  to alu IN_B.
- ALU_CIN  output  1  to alu Cin.
- ALU_BIN  output  1  to alu Bin.
- ALU_OUT  input  DWIDTH  from alu OUT.
- ALU_COUT  input  1  from alu Cout.
- ALU_BOUT  input  1  from alu Bout.
- RES_VALID  output  1  result available.
- RES_READY  input  1  result consumed.
- RES_DATA  output  NWORDS*DWIDTH  result.
- RES_CB  output  1  final carry-out (ADD/INC) or borrow-out (SUB/DEC).
- RES_ZERO  output  1  RES_DATA == 0.
- BUSY  output  1  high in RUN.

Behaviour:
- ALU contract (combinational, same cycle):
  - ADD is ALU_INSTR=4'h5: OUT = A+B+Cin, Cout = carry.
  - SUB is ALU_INSTR=4'h4: OUT = A-B-Bin, Bout = borrow.
  - NOP is ALU_INSTR=4'h0.
- FSM states IDLE, RUN, DONE; one-hot or binary encoding, implementer's choice.
- Reset (RST=1 at posedge) from any state:
  - state=IDLE, word index=0, result and operand registers=0, chain flag=0.
  - RES_VALID=0, RES_CB=0, RES_ZERO=0 (forced low in IDLE), BUSY=0, CMD_READY=1.
  - ALU_INSTR=4'h0, ALU_A/ALU_B/ALU_CIN/ALU_BIN=0.
  - Reset mid-RUN or in DONE aborts: no result is delivered.
- IDLE:
  - CMD_READY=1; ALU outputs at NOP/zero.
  - On CMD_VALID=1, capture CMD_OP/CMD_A/CMD_B; go to RUN with idx=0.
  - Chain flag := CMD_CB for ADD/SUB, 1 for INC/DEC.
- RUN (CMD_READY=0, BUSY=1), one word per cycle:
  - ALU_A = A word[idx].
  - ALU_B = B word[idx] for ADD/SUB, 0 for INC/DEC.
  - ALU_INSTR = 4'h5 for ADD/INC, 4'h4 for SUB/DEC.
  - ALU_CIN = chain flag when the op is ADD/INC, else 0.
  - ALU_BIN = chain flag when the op is SUB/DEC, else 0.
  - At posedge: result word[idx] := ALU_OUT; chain flag := ALU_COUT (add ops) or ALU_BOUT (sub ops); idx++.
  - After the word idx=NWORDS-1 edge, go to DONE.
- Latency: the accept edge is k; RES_VALID rises after edge k+NWORDS; throughput is one command per NWORDS+2 cycles minimum.
- DONE:
  - RES_VALID=1; RES_DATA, RES_CB (= final chain flag) and RES_ZERO stable.
  - ALU outputs at NOP; CMD_READY=0.
  - On RES_READY=1 at posedge, go to IDLE. No accept in the same cycle.
- Boundary behaviour:
  - CMD_VALID in RUN/DONE is ignored with no side effects.
  - RES_READY outside DONE is ignored.
  - Command inputs may change after the accept edge without affecting the result.
  - idx wraps only via FSM return to IDLE.
  - Unsigned modulo 2^(NWORDS*DWIDTH) arithmetic.

Test Plan (DWIDTH=8, NWORDS=4):
- ADD A=0x000000FF B=0x00000001 CB=0 -> RES_DATA=0x00000100, RES_CB=0, RES_ZERO=0. RES_VALID high exactly 4 edges after accept. ALU_INSTR=4'h5 for 4 cycles with ALU_CIN = 0,1,0,0.
- ADD 0xFFFFFFFF + 0x00000001 CB=0 -> 0x00000000, RES_CB=1, RES_ZERO=1. Then ADD 0x00000004 + 0x00000002 CB=1 -> 0x00000007.
- SUB 0x00000100 - 0x00000001 CB=0 -> 0x000000FF, RES_CB=0. SUB 0x00000003 - 0x0000001F CB=1 -> 0xFFFFFFE3, RES_CB=1; ALU_INSTR=4'h4 throughout RUN.
- INC 0x00FFFFFF -> 0x01000000, RES_CB=0. DEC 0x00000000 -> 0xFFFFFFFF, RES_CB=1. DEC 0x00000070 -> 0x0000006F.
- Backpressure: hold RES_READY=0 for 5 cycles in DONE -> RES_VALID/RES_DATA/RES_CB stable, CMD_READY=0. A CMD_VALID pulse during RUN and DONE is ignored. RES_READY=1 -> IDLE next cycle, CMD_READY=1.
- RST pulse during RUN at idx=2 -> next cycle IDLE, CMD_READY=1, BUSY=0, RES_VALID=0, ALU_INSTR=4'h0. A following ADD 0x12345678 + 0x11111111 -> 0x23456789.
